// File: rtl/hs_pkg.sv
// -----------------------------------------------------------------------------
// hs_pkg
// Shared constants and types for the handshake receive path. hs_rx_fifo and
// handshake_top both use these, so the defaults and the statistic counter
// type stay the same in both places.
//
// Contents:
//   HS_WIDTH_DEFAULT : default data width in bits (8)
//   HS_DEPTH_DEFAULT : default queue depth in entries (4)
//   hs_stat_t        : 16-bit accepted-word statistic counter
// -----------------------------------------------------------------------------
package hs_pkg;

  localparam int HS_WIDTH_DEFAULT = 8;
  localparam int HS_DEPTH_DEFAULT = 4;

  typedef logic [15:0] hs_stat_t;

endpackage : hs_pkg

// File: rtl/hs_rx_fifo_mem.sv
// -----------------------------------------------------------------------------
// hs_rx_fifo_mem
// A register array with one write port and one read port, plus the read and
// write pointers. The array holds every queued word, including the word that
// the parent module has copied into its output register. That word sits at
// the read pointer, so the read port presents the entry after it (the next
// head) for the parent to load when a pop occurs.
//
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset, clears both pointers
//   i_push       : write i_wdata at the write pointer and advance it
//   i_pop        : advance the read pointer
//   i_wdata      : write data
//   o_next_data  : entry at read pointer + 1 (the next head word)
// -----------------------------------------------------------------------------
module hs_rx_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_next_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    w_next_ptr;

  // DEPTH is a power of two, so the pointers wrap modulo DEPTH through
  // ordinary binary overflow. No extra compare logic is needed.
  always_ff @(posedge clk) begin
    // NOTE: always use non-blocking (<=) in clocked blocks. Every register
    // then samples the values from before the edge, as flip-flops do.
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset on purpose. The pointers and the
  // parent's count say which entries are live. Leaving the array out of reset
  // lets it map onto plain registers or RAM without a reset network.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign w_next_ptr  = r_rd_ptr + 1'b1;
  assign o_next_data = r_mem[w_next_ptr];

endmodule : hs_rx_fifo_mem

// File: rtl/hs_rx_fifo.sv
// -----------------------------------------------------------------------------
// hs_rx_fifo
// A valid/ready receive queue. The head word is held in an output register,
// so out_data comes from a flop. in_ready is decoded only from the registered
// count, so there is no combinational path from out_ready to in_ready.
//
// Parameters:
//   WIDTH : data width in bits (default HS_WIDTH_DEFAULT)
//   DEPTH : entries, a power of two and at least 2 (default HS_DEPTH_DEFAULT)
//
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : upstream offers in_data
//   in_data   : upstream data word
//   in_ready  : a word can be accepted this cycle (count < DEPTH)
//   out_valid : out_data holds a valid head word
//   out_data  : head word, registered
//   out_ready : consumer takes out_data
//   count     : words held, including the output register
//   xfer_cnt  : count of accepted words, wrapping at 16 bits
//
// Build option:
//   HS_RX_FIFO_STATS_EN : when defined, xfer_cnt counts pushes. When not
//                         defined, xfer_cnt is tied to 0 and no counter is
//                         built.
// -----------------------------------------------------------------------------
module hs_rx_fifo
  import hs_pkg::*;
#(
  parameter int WIDTH = HS_WIDTH_DEFAULT,
  parameter int DEPTH = HS_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output hs_stat_t               xfer_cnt
);

  localparam int              CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);

  logic [CW-1:0]    r_count;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;

  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_count_nxt;
  logic             w_out_valid_nxt;
  logic [WIDTH-1:0] w_out_data_nxt;
  logic [WIDTH-1:0] w_mem_next;

  assign in_ready  = (r_count < FULL);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign count     = r_count;

  assign w_push = in_valid & in_ready;
  assign w_pop  = r_out_valid & out_ready;

  hs_rx_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_wdata     (in_data),
    .o_next_data (w_mem_next)
  );

  // The output register mirrors the head entry of the array. On a pop, the
  // next head comes from the array if another word is already stored. If the
  // queue held a single word, the next head can only be the word pushed on
  // the same edge, which is written into the array on that edge too, so it
  // is taken from in_data directly.
  always_comb begin
    // NOTE: give every variable a default first. A branch that does not
    // assign it would otherwise infer a latch.
    w_count_nxt     = r_count;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;

    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase

    if (w_pop) begin
      if (r_count > CW'(1)) begin
        w_out_data_nxt = w_mem_next;
      end else if (w_push) begin
        w_out_data_nxt = in_data;
      end else begin
        w_out_valid_nxt = 1'b0;
      end
    end else if (!r_out_valid && w_push) begin
      w_out_valid_nxt = 1'b1;
      w_out_data_nxt  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_count     <= w_count_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
    end
  end

`ifdef HS_RX_FIFO_STATS_EN
  hs_stat_t r_xfer_cnt;

  always_ff @(posedge clk) begin
    if (rst)         r_xfer_cnt <= '0;
    else if (w_push) r_xfer_cnt <= r_xfer_cnt + 1'b1;
  end

  assign xfer_cnt = r_xfer_cnt;
`else
  assign xfer_cnt = '0;
`endif

endmodule : hs_rx_fifo

// File: tb/tb_hs_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_hs_rx_fifo
// Self-checking bench for hs_rx_fifo (WIDTH=8, DEPTH=4). The reference is a
// queue of words: pushes append and pops remove from the front. After every
// cycle each output is compared with what that queue implies. Directed
// sequences cover the corner cases, then randomized traffic with occasional
// resets follows. Building with HS_RX_FIFO_STATS_EN also checks the
// statistic counter, including its wrap.
// -----------------------------------------------------------------------------
module tb_hs_rx_fifo;
  import hs_pkg::*;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic [CW-1:0] count;
  hs_stat_t      xfer_cnt;

  hs_rx_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .xfer_cnt  (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state.
  logic [W-1:0] m_q[$];
  bit           m_zero;   // no push since the last reset: out_data must be 0
  hs_stat_t     m_xfer;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("count",     32'(count),     32'(m_q.size()));
    check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    check("in_ready",  32'(in_ready),  32'(m_q.size() < D));
    check("xfer_cnt",  32'(xfer_cnt),  32'(m_xfer));
    if (m_q.size() != 0) check("out_data", 32'(out_data), 32'(m_q[0]));
    else if (m_zero)     check("out_data_rst", 32'(out_data), 32'h0);
  endtask

  // One clock cycle. Inputs are applied at the falling edge and the model is
  // updated at the rising edge. The outputs are checked at the next falling
  // edge.
  task automatic step(input bit r, input bit v, input logic [W-1:0] d, input bit ordy);
    bit do_push;
    bit do_pop;
    rst       = r;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    do_push = v && (m_q.size() < D);
    do_pop  = (m_q.size() != 0) && ordy;
    if (r) begin
      m_q.delete();
      m_zero = 1'b1;
      m_xfer = '0;
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back(d);
        m_zero = 1'b0;
`ifdef HS_RX_FIFO_STATS_EN
        m_xfer = m_xfer + 16'd1;
`endif
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    m_zero    = 1'b1;
    m_xfer    = '0;
    @(negedge clk);

    // Reset, with junk offered at the input.
    step(1, 1, 8'hEE, 1);
    step(1, 0, 8'h00, 0);

    // Single word into an empty queue, then popped.
    step(0, 1, 8'hA5, 1);
    check("lat_valid", 32'(out_valid), 32'h1);
    check("lat_data",  32'(out_data),  32'hA5);
    step(0, 0, 8'h5A, 1);
    check("lat_drained", 32'(count), 32'h0);

    // Fill to full with the consumer stalled, offer a fifth word, then drain.
    for (int i = 1; i <= 4; i++) step(0, 1, 8'(i), 0);
    check("full_ready", 32'(in_ready), 32'h0);
    step(0, 1, 8'h05, 0);
    check("full_hold", 32'(count), 32'h4);
    for (int i = 0; i < 4; i++) step(0, 0, 8'hFF, 1);

    // Pop while full: no push on that cycle, then the push goes in next cycle.
    for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h20 + i), 0);
    step(0, 1, 8'h10, 1);
    check("full_pop_cnt", 32'(count), 32'h3);
    step(0, 1, 8'h10, 0);
    check("full_refill_cnt", 32'(count), 32'h4);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1);

    // Continuous streaming: one word per cycle through the wrapping pointers.
    for (int i = 0; i < 10; i++) step(0, 1, 8'(i), 1);
    step(0, 0, 8'h00, 1);

    // Reset in the middle of traffic with three words held.
    for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h60 + i), 0);
    step(1, 1, 8'h77, 1);
    check("rst_mid_cnt", 32'(count), 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 1);

`ifdef HS_RX_FIFO_STATS_EN
    // Force the statistic near its wrap point, then push three words.
    step(1, 0, 8'h00, 0);
    force dut.r_xfer_cnt = 16'hFFFE;
    #1;
    release dut.r_xfer_cnt;
    m_xfer = 16'hFFFE;
    for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h30 + i), 1);
    check("xfer_wrap", 32'(xfer_cnt), 32'h1);
    step(0, 0, 8'h00, 1);
`endif

    // Randomized traffic, including rare resets and random data on idle cycles.
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 40) == 0, $urandom_range(0, 1) == 1, 8'($urandom),
           ($urandom % 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_hs_rx_fifo
